// File: rtl/clk_div_pkg.sv
// Shared defaults and types for the programmable clock divider.
// Optional feature macro used by this design: CLK_DIV_SYNC_EN.
package clk_div_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int DIV_RST_DEF = 100000;
    localparam int MAX_CH      = 16;

    typedef logic [CNT_W_DEF-1:0] div_word_t;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, toggle flop, tick pulse and shadowed divisor.
// With CLK_DIV_SYNC_EN defined, a sync input restarts the channel in phase.
module clk_div_channel #(
    parameter int CNT_W   = 32,
    parameter int DIV_RST = 100000
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_div,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    // A new divisor only takes effect at a wrap, so half-periods stay whole.
    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        clk_d     = clk_q;
        tick_d    = 1'b0;
`ifdef CLK_DIV_SYNC_EN
        if (sync) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (pending_q) begin
                div_d     = shadow_q;
                pending_d = 1'b0;
            end
        end else
`endif
        if (en) begin
            if (cnt_q == div_q) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = 1'b1;
                if (pending_q) begin
                    div_d     = shadow_q;
                    pending_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (cfg_we) begin
            shadow_d  = cfg_div;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            div_q     <= CNT_W'(DIV_RST);
            shadow_q  <= CNT_W'(DIV_RST);
            pending_q <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: rtl/clk_divider_prog.sv
// Multi-channel programmable clock divider with valid/ready divisor updates.
// Define CLK_DIV_SYNC_EN to add the global sync input.
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic                        clk_in,
    input  logic                        reset,
`ifdef CLK_DIV_SYNC_EN
    input  logic                        sync,
`endif
    input  logic [NUM_CH-1:0]           en,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]            cfg_div,
    output logic [NUM_CH-1:0]           clk_out,
    output logic [NUM_CH-1:0]           tick
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] pending;
    logic              ch_in_range;
    logic              handshake;

    // Out-of-range channels always look ready so their writes drain harmlessly.
    assign ch_in_range = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
    assign cfg_ready   = ch_in_range ? ~pending[cfg_ch] : 1'b1;
    assign handshake   = cfg_valid && cfg_ready && ch_in_range;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_RST)
        ) u_channel (
            .clk_in  (clk_in),
            .reset   (reset),
            .en      (en[i]),
            .cfg_we  (handshake && (cfg_ch == CH_W'(i))),
            .cfg_div (cfg_div),
`ifdef CLK_DIV_SYNC_EN
            .sync    (sync),
`endif
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed self-checking bench for clk_divider_prog (NUM_CH=4, DIV_RST=4).
// Exercises the sync feature only when CLK_DIV_SYNC_EN is defined.
module tb_clk_divider_prog;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] en     = 4'h0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_ch  = 2'd0;
    logic [7:0] cfg_div = 8'd0;
    logic [3:0] clk_out;
    logic [3:0] tick;
`ifdef CLK_DIV_SYNC_EN
    logic       sync = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    clk_divider_prog #(
        .NUM_CH  (4),
        .CNT_W   (8),
        .DIV_RST (4)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
`ifdef CLK_DIV_SYNC_EN
        .sync      (sync),
`endif
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic waitEdge();
        @(posedge clk_in);
        #1;
        edge_n++;
    endtask

    task automatic applyReset();
        reset     = 1'b1;
        cfg_valid = 1'b0;
`ifdef CLK_DIV_SYNC_EN
        sync      = 1'b0;
`endif
        @(posedge clk_in);
        #1;
        reset  = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state and the basic divide-by-10 waveform.
        $display("[TB] reset and default divisor");
        en = 4'hF;
        #1;
        checkOutput("rst clk_out", clk_out, 4'h0);
        checkOutput("rst tick", tick, 4'h0);
        checkOutput("rst ready", cfg_ready, 1'b1);
        applyReset();
        for (int e = 1; e <= 15; e++) begin
            waitEdge();
            checkOutput("A clk_out", clk_out, ((e / 5) % 2 == 1) ? 4'hF : 4'h0);
            checkOutput("A tick", tick, (e % 5 == 0) ? 4'hF : 4'h0);
        end

        // Divisor update on ch1 mid half-period, then an immediate re-write.
        $display("[TB] ch1 reconfiguration");
        applyReset();
        en = 4'hF;
        waitEdge();
        waitEdge();
        cfg_ch  = 2'd1;
        cfg_div = 8'd1;
        #1;
        checkOutput("B ready pre", cfg_ready, 1'b1);
        for (int e = 3; e <= 11; e++) begin
            cfg_valid = (e == 3 || e == 6);
            waitEdge();
            checkOutput("B ready", cfg_ready, !(e == 3 || e == 4 || e == 6));
            checkOutput("B clk1", clk_out[1], (e < 5) ? 1'b0 : (((e - 5) / 2) % 2 == 0));
            checkOutput("B tick1", tick[1], (e == 5 || e == 7 || e == 9 || e == 11));
            checkOutput("B clk0", clk_out[0], (e >= 5 && e < 10));
        end
        cfg_valid = 1'b0;

        // Divisor 0 on ch2 gives a toggle and a tick on every edge.
        $display("[TB] ch2 divisor zero");
        applyReset();
        en        = 4'hF;
        cfg_ch    = 2'd2;
        cfg_div   = 8'd0;
        cfg_valid = 1'b1;
        waitEdge();
        cfg_valid = 1'b0;
        checkOutput("C ready pend", cfg_ready, 1'b0);
        for (int e = 2; e <= 12; e++) begin
            waitEdge();
            checkOutput("C tick2", tick[2], (e >= 5));
            checkOutput("C clk2", clk_out[2], (e >= 5) && ((e - 5) % 2 == 0));
        end
        checkOutput("C ready done", cfg_ready, 1'b1);

        // Freeze ch3 at cnt=2 for seven edges.
        $display("[TB] ch3 enable freeze");
        applyReset();
        en = 4'hF;
        waitEdge();
        waitEdge();
        en = 4'b0111;
        for (int e = 3; e <= 9; e++) begin
            waitEdge();
            checkOutput("D clk3 frozen", clk_out[3], 1'b0);
            checkOutput("D tick3 frozen", tick[3], 1'b0);
        end
        checkOutput("D clk0 running", clk_out[0], 1'b1);
        en = 4'hF;
        waitEdge();
        checkOutput("D tick0 e10", tick[0], 1'b1);
        checkOutput("D tick3 e10", tick[3], 1'b0);
        waitEdge();
        checkOutput("D tick3 e11", tick[3], 1'b0);
        waitEdge();
        checkOutput("D tick3 e12", tick[3], 1'b1);
        checkOutput("D clk3 e12", clk_out[3], 1'b1);
        checkOutput("D clk0 e12", clk_out[0], 1'b0);

        // Asynchronous reset between edges discards a pending ch0 update.
        $display("[TB] async reset with pending update");
        applyReset();
        en = 4'hF;
        for (int e = 1; e <= 5; e++) waitEdge();
        cfg_ch    = 2'd0;
        cfg_div   = 8'd1;
        cfg_valid = 1'b1;
        waitEdge();
        cfg_valid = 1'b0;
        checkOutput("E ready pend", cfg_ready, 1'b0);
        waitEdge();
        checkOutput("E clk_out pre", clk_out, 4'hF);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("E clk_out rst", clk_out, 4'h0);
        checkOutput("E tick rst", tick, 4'h0);
        checkOutput("E ready rst", cfg_ready, 1'b1);
        #1;
        reset  = 1'b0;
        edge_n = 0;
        for (int e = 1; e <= 5; e++) begin
            waitEdge();
            checkOutput("E clk0", clk_out[0], (e == 5));
            checkOutput("E tick0", tick[0], (e == 5));
        end

`ifdef CLK_DIV_SYNC_EN
        // Sync on the same edge as the ch0 wrap restarts every channel in phase.
        $display("[TB] sync coincident with wrap");
        applyReset();
        en = 4'hF;
        for (int e = 1; e <= 4; e++) waitEdge();
        sync = 1'b1;
        waitEdge();
        sync = 1'b0;
        checkOutput("F clk_out sync", clk_out, 4'h0);
        checkOutput("F tick sync", tick, 4'h0);
        for (int e = 6; e <= 10; e++) begin
            waitEdge();
            checkOutput("F clk_out", clk_out, (e == 10) ? 4'hF : 4'h0);
            checkOutput("F tick", tick, (e == 10) ? 4'hF : 4'h0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
